// File: rtl/vga_timing_rx_if.sv
// rtl/vga_timing_rx_if.sv - video input and measurement bundle for vga_timing_rx
interface vga_timing_rx_if #(
  parameter int CW = 12
);
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          rx_de;
  logic [CW-1:0] rx_x;
  logic [CW-1:0] rx_y;
  logic [CW-1:0] h_total;
  logic [CW-1:0] h_active;
  logic [CW-1:0] h_sync;
  logic [CW-1:0] v_total;
  logic [CW-1:0] v_active;
  logic          locked;
  logic          frame_start;
  logic          sync_err;

  modport master (
    output hsync, vsync, de,
    input  rx_de, rx_x, rx_y, h_total, h_active, h_sync, v_total, v_active,
    input  locked, frame_start, sync_err
  );

  modport slave (
    input  hsync, vsync, de,
    output rx_de, rx_x, rx_y, h_total, h_active, h_sync, v_total, v_active,
    output locked, frame_start, sync_err
  );
endinterface

// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA timing receiver: measures line/frame timing, locks, recovers coordinates
module vga_timing_rx #(
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int CW          = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_timing_rx_if.slave vif
);
  localparam logic [CW-1:0] MAX = '1;
  localparam int MW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  state_t        r_state;
  logic          r_hs, r_vs, r_de, r_hs_d, r_vs_d, r_de_d;
  logic [CW-1:0] r_hcnt, r_hsw, r_decnt;
  logic [CW-1:0] r_f_lines, r_f_active, r_f_len, r_f_sync, r_f_de;
  logic          r_f_href, r_f_dref, r_f_ok, r_skip;
  logic [CW-1:0] r_s_len, r_s_sync, r_s_de, r_s_lines, r_s_active;
  logic [MW-1:0] r_match;
  logic [CW-1:0] r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active;
  logic          r_locked, r_sync_err, r_frame_start;
  logic [CW-1:0] r_xcnt, r_ycnt, r_rx_x, r_rx_y;
  logic          r_rx_de;

  logic          w_hs_edge, w_vs_edge, w_de_fall, w_len_sat, w_skip;
  logic          w_m_eq, w_m_ok, w_lock_err;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_n_lines, w_n_active, w_n_len, w_n_sync, w_n_de;
  logic          w_n_href, w_n_dref, w_n_ok;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + CW'(1);
  endfunction

  assign w_hs_edge = r_hs & ~r_hs_d;
  assign w_vs_edge = r_vs & ~r_vs_d;
  assign w_de_fall = r_de_d & ~r_de;
  assign w_len_sat = (r_hcnt == MAX);
  assign w_len     = w_len_sat ? MAX : r_hcnt + CW'(1);
  // The line completing on the first hs edge after leaving SEARCH may have started mid-line.
  assign w_skip    = r_skip | ((r_state == S_SEARCH) & w_vs_edge);
  assign w_m_eq    = ({r_f_len, r_f_sync, r_f_de, r_f_lines, r_f_active} ==
                      {r_s_len, r_s_sync, r_s_de, r_s_lines, r_s_active});
  assign w_m_ok    = r_f_ok & r_f_href & (r_f_lines != '0);
  assign w_lock_err = (w_hs_edge & (w_len_sat | (w_len != r_h_total))) |
                      (w_vs_edge & (r_f_lines != r_v_total));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_hs, r_vs, r_de, r_hs_d, r_vs_d, r_de_d} <= '0;
      r_hcnt  <= '0;
      r_hsw   <= '0;
      r_decnt <= '0;
    end else begin
      r_hs   <= (vif.hsync == HSYNC_POL);
      r_vs   <= (vif.vsync == VSYNC_POL);
      r_de   <= vif.de;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_de_d <= r_de;
      if (w_hs_edge) begin
        r_hcnt  <= '0;
        r_hsw   <= CW'(1);
        r_decnt <= CW'(r_de);
      end else begin
        r_hcnt <= sat_inc(r_hcnt);
        if (r_hs) r_hsw <= sat_inc(r_hsw);
        if (r_de) r_decnt <= sat_inc(r_decnt);
      end
    end
  end

  // Frame accumulator: a vs edge opens a new window, and a coincident hs edge lands in it.
  always_comb begin
    w_n_lines  = r_f_lines;
    w_n_active = r_f_active;
    w_n_len    = r_f_len;
    w_n_sync   = r_f_sync;
    w_n_de     = r_f_de;
    w_n_href   = r_f_href;
    w_n_dref   = r_f_dref;
    w_n_ok     = r_f_ok;
    if (w_vs_edge) begin
      w_n_lines  = '0;
      w_n_active = '0;
      w_n_len    = '0;
      w_n_sync   = '0;
      w_n_de     = '0;
      w_n_href   = 1'b0;
      w_n_dref   = 1'b0;
      w_n_ok     = 1'b1;
    end
    if (w_hs_edge) begin
      w_n_lines = sat_inc(w_n_lines);
      if (r_decnt != '0) w_n_active = sat_inc(w_n_active);
      if (!w_skip) begin
        if (w_len_sat) w_n_ok = 1'b0;
        if (!w_n_href) begin
          w_n_len  = w_len;
          w_n_sync = r_hsw;
          w_n_href = 1'b1;
        end else if ((w_len != w_n_len) || (r_hsw != w_n_sync)) begin
          w_n_ok = 1'b0;
        end
        if (r_decnt != '0) begin
          if (!w_n_dref) begin
            w_n_de   = r_decnt;
            w_n_dref = 1'b1;
          end else if (r_decnt != w_n_de) begin
            w_n_ok = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_f_lines, r_f_active, r_f_len, r_f_sync, r_f_de} <= '0;
      {r_f_href, r_f_dref, r_f_ok, r_skip} <= '0;
    end else begin
      r_f_lines  <= w_n_lines;
      r_f_active <= w_n_active;
      r_f_len    <= w_n_len;
      r_f_sync   <= w_n_sync;
      r_f_de     <= w_n_de;
      r_f_href   <= w_n_href;
      r_f_dref   <= w_n_dref;
      r_f_ok     <= w_n_ok;
      r_skip     <= w_skip & ~w_hs_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_SEARCH;
      r_match       <= '0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_frame_start <= 1'b0;
      {r_s_len, r_s_sync, r_s_de, r_s_lines, r_s_active} <= '0;
      {r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active} <= '0;
    end else begin
      r_sync_err    <= 1'b0;
      r_frame_start <= w_vs_edge;
      case (r_state)
        S_SEARCH: if (w_vs_edge) r_state <= S_MEASURE;
        S_MEASURE: if (w_vs_edge) begin
          {r_s_len, r_s_sync, r_s_de, r_s_lines, r_s_active} <=
            {r_f_len, r_f_sync, r_f_de, r_f_lines, r_f_active};
          if (w_m_eq && w_m_ok) begin
            r_match <= r_match + MW'(1);
            if (r_match + MW'(1) == MW'(LOCK_FRAMES)) begin
              r_state    <= S_LOCKED;
              r_locked   <= 1'b1;
              r_h_total  <= r_s_len;
              r_h_sync   <= r_s_sync;
              r_h_active <= r_s_de;
              r_v_total  <= r_s_lines;
              r_v_active <= r_s_active;
            end
          end else begin
            r_match <= '0;
          end
        end
        S_LOCKED: if (w_lock_err) begin
          // Stored set is cleared so relock needs the full sequence of fresh frames.
          r_state    <= S_SEARCH;
          r_locked   <= 1'b0;
          r_match    <= '0;
          r_sync_err <= 1'b1;
          {r_s_len, r_s_sync, r_s_de, r_s_lines, r_s_active} <= '0;
        end
        default: r_state <= S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xcnt  <= '0;
      r_ycnt  <= '0;
      r_rx_x  <= '0;
      r_rx_y  <= '0;
      r_rx_de <= 1'b0;
    end else begin
      if (r_de) r_xcnt <= sat_inc(r_xcnt);
      else      r_xcnt <= '0;
      if (w_vs_edge)      r_ycnt <= '0;
      else if (w_de_fall) r_ycnt <= sat_inc(r_ycnt);
      r_rx_de <= r_de;
      r_rx_x  <= r_xcnt;
      r_rx_y  <= r_ycnt;
    end
  end

  assign vif.rx_de       = r_rx_de;
  assign vif.rx_x        = r_rx_x;
  assign vif.rx_y        = r_rx_y;
  assign vif.h_total     = r_h_total;
  assign vif.h_active    = r_h_active;
  assign vif.h_sync      = r_h_sync;
  assign vif.v_total     = r_v_total;
  assign vif.v_active    = r_v_active;
  assign vif.locked      = r_locked;
  assign vif.frame_start = r_frame_start;
  assign vif.sync_err    = r_sync_err;
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb/tb_vga_timing_rx.sv - scoreboard bench for vga_timing_rx, both sync polarities
`timescale 1ns/1ps
module tb_vga_timing_rx;
  localparam int CW    = 12;
  localparam int H_ACT = 64, H_FP = 4, H_SW = 10, H_TOT = 80;
  localparam int V_ACT = 10, V_FP = 1, V_SW = 2, V_TOT = 14;
  localparam int HS0   = H_ACT + H_FP;
  localparam int VS0   = V_ACT + V_FP;
  localparam int VS1   = VS0 + V_SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs_n = 1'b1, vs_n = 1'b1, de = 1'b0;
  always #5 clk = ~clk;

  vga_timing_rx_if #(.CW(CW)) if_a ();
  vga_timing_rx_if #(.CW(CW)) if_b ();

  assign if_a.hsync = hs_n;
  assign if_a.vsync = vs_n;
  assign if_a.de    = de;
  assign if_b.hsync = ~hs_n;
  assign if_b.vsync = ~vs_n;
  assign if_b.de    = de;

  vga_timing_rx #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW), .LOCK_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .vif(if_a));
  vga_timing_rx #(.HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(CW), .LOCK_FRAMES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .vif(if_b));

  logic [87:0] out_a, out_b;
  assign out_a = {if_a.rx_de, if_a.rx_x, if_a.rx_y, if_a.h_total, if_a.h_active, if_a.h_sync,
                  if_a.v_total, if_a.v_active, if_a.locked, if_a.frame_start, if_a.sync_err};
  assign out_b = {if_b.rx_de, if_b.rx_x, if_b.rx_y, if_b.h_total, if_b.h_active, if_b.h_sync,
                  if_b.v_total, if_b.v_active, if_b.locked, if_b.frame_start, if_b.sync_err};

  int n_tests = 0, n_fail = 0;
  int cyc = 0, vs_cnt = 0, vs_cyc = -100, exp_err_cyc = -1;
  int err_a = 0, err_b = 0;
  logic vs_prev = 1'b0, sb_on = 1'b0, lk_a_prev = 1'b0, lk_b_prev = 1'b0;
  logic [63:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag, input logic [87:0] o);
    chk({tag, "_coord"}, 64'(o[87:63]), 64'd0);
    chk({tag, "_meas"},  64'(o[62:3]),  64'd0);
    chk({tag, "_flags"}, 64'(o[2:0]),   64'd0);
  endtask

  task automatic check_meas(input string tag, input logic [87:0] o);
    chk({tag, "_h"},  64'(o[62:27]), {28'd0, 12'(H_TOT), 12'(H_ACT), 12'(H_SW)});
    chk({tag, "_v"},  64'(o[26:3]),  {40'd0, 12'(V_TOT), 12'(V_ACT)});
  endtask

  task automatic drive_px(input logic h, input logic v, input logic d, input int x, input int y);
    @(posedge clk);
    #1;
    hs_n = ~h;
    vs_n = ~v;
    de   = d;
    if (v && !vs_prev) begin
      vs_cnt++;
      vs_cyc = cyc;
    end
    vs_prev = v;
    if (d && sb_on) sb_q.push_back({8'd0, 32'(cyc + 2), 12'(x), 12'(y)});
  endtask

  // One frame; line stretch_line gets one extra blanking clock, stop_line aborts early.
  task automatic gen_frame(input int stretch_line, input int stop_line);
    for (int ln = 0; ln < V_TOT; ln++) begin
      int len;
      if (ln == stop_line) return;
      len = (ln == stretch_line) ? H_TOT + 1 : H_TOT;
      for (int px = 0; px < len; px++) begin
        logic h, v, d;
        h = (px >= HS0) && (px < HS0 + H_SW);
        v = ((ln > VS0) || (ln == VS0 && px >= HS0)) && ((ln < VS1) || (ln == VS1 && px < HS0));
        d = (ln < V_ACT) && (px < H_ACT);
        drive_px(h, v, d, px, ln);
        if (stretch_line >= 0 && ln == stretch_line + 1 && px == HS0) begin
          exp_err_cyc = cyc + 2;
          vs_cnt = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_a.locked && !lk_a_prev) begin
        chk("lock_vs_a", 64'(vs_cnt), 64'd4);
        chk("lock_lat_a", 64'(cyc - vs_cyc), 64'd2);
      end
      if (if_b.locked && !lk_b_prev) begin
        chk("lock_vs_b", 64'(vs_cnt), 64'd4);
        chk("lock_lat_b", 64'(cyc - vs_cyc), 64'd2);
      end
      if (if_a.frame_start) chk("fs_lat_a", 64'(cyc - vs_cyc), 64'd2);
      if (if_a.sync_err) begin
        err_a <= err_a + 1;
        chk("err_cyc_a", 64'(cyc), 64'(exp_err_cyc));
      end
      if (if_b.sync_err) err_b <= err_b + 1;
      if (sb_on && if_a.rx_de) begin
        if (sb_q.size() == 0) chk("px_extra", 64'd1, 64'd0);
        else chk("px_a", {8'd0, 32'(cyc), if_a.rx_x, if_a.rx_y}, sb_q.pop_front());
      end
    end
    lk_a_prev <= if_a.locked;
    lk_b_prev <= if_b.locked;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_a", out_a);
    check_zero("rst_b", out_b);
    rst_n = 1'b1;

    for (int f = 0; f < 4; f++) gen_frame(-1, V_TOT);
    chk("locked_a", 64'(if_a.locked), 64'd1);
    chk("locked_b", 64'(if_b.locked), 64'd1);
    check_meas("meas_a", out_a);
    check_meas("meas_b", out_b);

    sb_on = 1'b1;
    gen_frame(-1, V_TOT);
    sb_on = 1'b0;
    chk("px_left", 64'(sb_q.size()), 64'd0);
    chk("no_err_a", 64'(err_a), 64'd0);
    chk("no_err_b", 64'(err_b), 64'd0);

    gen_frame(3, V_TOT);
    chk("stretch_err_a", 64'(err_a), 64'd1);
    chk("stretch_err_b", 64'(err_b), 64'd1);
    chk("unlock_a", 64'(if_a.locked), 64'd0);
    chk("unlock_b", 64'(if_b.locked), 64'd0);
    check_meas("hold_a", out_a);
    for (int f = 0; f < 3; f++) gen_frame(-1, V_TOT);
    chk("relock_a", 64'(if_a.locked), 64'd1);
    chk("relock_b", 64'(if_b.locked), 64'd1);

    gen_frame(-1, 5);
    rst_n = 1'b0;
    #1;
    check_zero("midrst_a", out_a);
    check_zero("midrst_b", out_b);
    hs_n = 1'b1; vs_n = 1'b1; de = 1'b0; vs_prev = 1'b0; vs_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) gen_frame(-1, V_TOT);
    chk("early_lock_a", 64'(if_a.locked), 64'd0);
    gen_frame(-1, V_TOT);
    chk("rst_relock_a", 64'(if_a.locked), 64'd1);
    chk("rst_relock_b", 64'(if_b.locked), 64'd1);
    check_meas("rst_meas_a", out_a);
    chk("total_err_a", 64'(err_a), 64'd1);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5000; i++) drive_px(1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 10; i++) drive_px(1'b0, 1'b1, 1'b0, 0, 0);
    end
    drive_px(1'b0, 1'b0, 1'b0, 0, 0);
    chk("sat_nolock_a", 64'(if_a.locked), 64'd0);
    chk("sat_nolock_b", 64'(if_b.locked), 64'd0);
    chk("sat_hcnt_a", 64'(dut_a.r_hcnt), 64'd4095);
    chk("sat_hcnt_b", 64'(dut_b.r_hcnt), 64'd4095);
    chk("sat_err_a", 64'(err_a), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive-side counterpart to the team's VGA timing generator.
- Samples incoming hsync/vsync/de in the pixel-clock domain and measures line and frame timing.
- Locks once the measured timing is stable, then recovers active-pixel coordinates for downstream capture/overlay logic.
- Sits at the video input of a design; intended use is loopback checks and sink-side pipelines.

Parameters:
HSYNC_POL, 0, hsync active level (0 = active-low, 1 = active-high)
VSYNC_POL, 0, vsync active level (0 = active-low, 1 = active-high)
CW, 12, width of all counters and measurement outputs
LOCK_FRAMES, 2, consecutive identical frame measurements required to assert locked

Ports:
clk  in  1  pixel clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
hsync  in  1  incoming horizontal sync, polarity per HSYNC_POL
vsync  in  1  incoming vertical sync, polarity per VSYNC_POL
de  in  1  incoming data enable, active-high
rx_de  out  1  de delayed to align with rx_x/rx_y
rx_x  out  CW  pixel index within the current active run
rx_y  out  CW  active-line index within the current frame
h_total  out  CW  measured clocks per line (locked value)
h_active  out  CW  measured de clocks per active line
h_sync  out  CW  measured hsync active width in clocks
v_total  out  CW  measured lines per frame
v_active  out  CW  measured lines containing de
locked  out  1  timing stable and valid
frame_start  out  1  one-cycle pulse at each registered vsync assertion edge
sync_err  out  1  one-cycle pulse when locked timing is violated

Behaviour:
- Reset (async, rst_n=0): every register and output is cleared to 0, including rx_*, all measurements, locked, frame_start and sync_err. FSM enters SEARCH.
- Input stage 1: hsync/vsync/de are registered. Syncs are normalised to active-high (hs, vs).
- Edges: hs/vs assertion edges are detected against the previous stage-1 value. The de falling edge is detected the same way.
- Line measurement (hcnt): cleared to 0 on each hs assertion edge, otherwise increments, saturating at 2^CW-1.
  - Line length = hcnt+1 at the hs edge; a saturated length marks the frame invalid.
  - Per-line hsync width = count of hs-active cycles.
  - Per-line de count = count of de cycles.
- Frame measurement: window runs from one vs assertion edge (inclusive) to the next (exclusive).
  - Lines = number of hs edges in the window. An hs edge coinciding with a vs edge belongs to the new frame.
  - v_active = number of lines with de count > 0.
  - The frame is consistent only if all line lengths, all hsync widths, and all nonzero de counts are equal within the frame. The partial first line after a vs edge in SEARCH is excluded.
- FSM:
  - SEARCH: wait for first vs edge, then go to MEASURE.
  - MEASURE: at each vs edge, compare the completed frame set M {len, sync, de, lines, active} to the stored set S.
    - If M == S and M is consistent: match_cnt+1; otherwise match_cnt = 0.
    - S <= M on every vs edge.
    - When match_cnt == LOCK_FRAMES: go to LOCKED, set locked=1, and drive h_*/v_* outputs from S.
  - LOCKED, checked at every hs edge and every vs edge: any line length != h_total, or frame line count != v_total, triggers the following.
    - sync_err pulses 1 cycle.
    - locked=0, match_cnt=0, and the FSM returns to SEARCH.
    - h_*/v_* outputs hold their last values.
- Measurement outputs update only on entry to LOCKED. They are stable while locked.
- Coordinates:
  - rx_x: increments each de cycle; cleared after a de falling edge.
  - rx_y: increments at each de falling edge; cleared at vs edge.
  - rx_de/rx_x/rx_y are registered: 2 clocks of latency from input de.
  - These outputs run regardless of lock; consumers qualify with locked && rx_de.
- frame_start pulses 1 cycle after the stage-1 vs edge, in all states.
- Boundaries:
  - A counter saturated at all-ones does not wrap.
  - A frame with no hs edges is invalid.
  - de asserted during hs is not an error.
  - rst_n asserted mid-frame clears immediately; relock requires the full sequence again.

Test Plan:
- 640x480 stimulus (800x525, hsync 96, active-low syncs) from the team generator -> locked rises one cycle after the 4th vs edge. Outputs read h_total=800, h_active=640, h_sync=96, v_total=525, v_active=480. sync_err never pulses.
- Locked, first active pixel of a frame -> rx_de=1, rx_x=0, rx_y=0, 2 clocks after input de rises. Last pixel -> rx_x=639, rx_y=479.
- Locked, one line stretched to 801 clocks -> sync_err pulses once at that hs edge, locked=0. Clean input afterwards -> relock after 4 vs edges.
- rst_n pulsed low mid-frame while locked -> all outputs are 0 immediately. Relock follows the normal sequence.
- HSYNC_POL=1, VSYNC_POL=1 with inverted sync stimulus -> identical measurements and lock timing as the first scenario.
- hsync held inactive for more than 2^CW clocks -> no lock is reached and hcnt stays saturated at 4095.
